// File: rtl/ascii_sep_pkg.sv
// Shared types and constants for the ascii_num_sep payload path.
//   ascii_mode_t : charset selector (DEC, HEX, FLOAT, PRINT)
//   afv_state_t  : frame validator FSM states
//   CH_*         : character codes the classifier treats specially
package ascii_sep_pkg;

  typedef enum logic [1:0] {
    MODE_DEC   = 2'd0,
    MODE_HEX   = 2'd1,
    MODE_FLOAT = 2'd2,
    MODE_PRINT = 2'd3
  } ascii_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } afv_state_t;

  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_DOT   = 8'h2E;

  // Inclusive range test on a character code.
  function automatic logic in_range(input logic [7:0] c, input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/ascii_char_class.sv
// Combinational character classifier.
//   ch        : input byte
//   mode      : charset to classify against
//   is_term   : byte is CR or LF (frame terminator, never stored)
//   is_valid  : byte belongs to the selected charset (after TAB mapping)
//   mapped_ch : byte to store; TAB becomes space when MAP_TAB is set
module ascii_char_class
  import ascii_sep_pkg::*;
#(
  parameter bit MAP_TAB = 1'b1
) (
  input  logic [7:0]  ch,
  input  ascii_mode_t mode,
  output logic        is_term,
  output logic        is_valid,
  output logic [7:0]  mapped_ch
);

  logic is_digit;
  logic is_dec;
  logic is_hex_letter;
  logic is_float_extra;
  logic is_tab_mapped;

  always_comb begin
    is_term        = (ch == CH_CR) || (ch == CH_LF);
    is_digit       = in_range(ch, 8'h30, 8'h39);
    is_dec         = is_digit || (ch == CH_SP) || (ch == CH_MINUS);
    is_hex_letter  = in_range(ch, 8'h41, 8'h46) || in_range(ch, 8'h61, 8'h66);
    is_float_extra = (ch == CH_DOT) || (ch == CH_PLUS) || (ch == 8'h65) || (ch == 8'h45);
    is_tab_mapped  = MAP_TAB && (ch == CH_TAB);
    mapped_ch      = is_tab_mapped ? CH_SP : ch;

    is_valid = 1'b0;
    unique case (mode)
      MODE_DEC:   is_valid = is_dec;
      MODE_HEX:   is_valid = is_dec || is_hex_letter;
      MODE_FLOAT: is_valid = is_dec || is_float_extra;
      MODE_PRINT: is_valid = in_range(ch, 8'h20, 8'h7E);
      default:    is_valid = 1'b0;
    endcase
    // A mapped TAB is stored as a space, so it is valid wherever a space is.
    if (is_tab_mapped) begin
      is_valid = 1'b1;
    end
  end

endmodule

// File: rtl/ascii_frame_validator.sv
// Frame validator: accepts one payload frame, drops CR/LF, classifies each byte against the
// charset latched on the first beat, and stores it in an inferred RAM for the number separator.
//   clk, rst_n      : clock, synchronous active-low reset
//   clear           : synchronous frame clear, back to IDLE
//   mode            : charset select, latched on the first accepted beat
//   payload_*       : valid/ready byte stream with last marker
//   rd_addr/rd_data : registered read port, 1-cycle latency, 0 beyond buffer_length
//   buffer_length   : stored byte count, valid while done
//   done            : frame complete (sticky until clear/reset)
//   invalid/err_pos : any out-of-charset byte seen / stored index of the first one
//   overflow        : more than DEPTH non-terminator bytes seen
module ascii_frame_validator
  import ascii_sep_pkg::*;
#(
  parameter int unsigned DEPTH   = 2048,
  parameter int unsigned ADDR_W  = $clog2(DEPTH),
  parameter bit          MAP_TAB = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [1:0]        mode,
  input  logic [7:0]        payload_data,
  input  logic              payload_valid,
  input  logic              payload_last,
  output logic              payload_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [ADDR_W:0]   buffer_length,
  output logic              done,
  output logic              invalid,
  output logic [ADDR_W:0]   err_pos,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FullCnt = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] OneCnt  = {{ADDR_W{1'b0}}, 1'b1};

  afv_state_t      state_q, state_d;
  ascii_mode_t     mode_q, mode_d;
  ascii_mode_t     cls_mode;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [ADDR_W:0] err_pos_q, err_pos_d;
  logic            invalid_q, invalid_d;
  logic            overflow_q, overflow_d;
  logic            rd_zero_q, rd_zero_d;
  logic [7:0]      ram_rd_q;
  logic [7:0]      ram [DEPTH];

  logic            is_term;
  logic            is_valid;
  logic [7:0]      mapped_ch;
  logic            accept;
  logic            full;
  logic            store;

  // The first beat is classified with the live mode input, since mode_q is only loaded by it.
  assign cls_mode = (state_q == IDLE) ? ascii_mode_t'(mode) : mode_q;

  ascii_char_class #(
    .MAP_TAB (MAP_TAB)
  ) u_char_class (
    .ch        (payload_data),
    .mode      (cls_mode),
    .is_term   (is_term),
    .is_valid  (is_valid),
    .mapped_ch (mapped_ch)
  );

  assign payload_ready = (state_q != DONE);
  // clear and reset both discard a coincident beat, including its RAM write.
  assign accept        = rst_n && !clear && payload_valid && payload_ready;
  assign full          = (wr_ptr_q == FullCnt);
  assign store         = accept && !is_term && !full;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    wr_ptr_d   = wr_ptr_q;
    len_d      = len_q;
    err_pos_d  = err_pos_q;
    invalid_d  = invalid_q;
    overflow_d = overflow_q;

    if (clear) begin
      state_d    = IDLE;
      mode_d     = MODE_DEC;
      wr_ptr_d   = '0;
      len_d      = '0;
      err_pos_d  = '0;
      invalid_d  = 1'b0;
      overflow_d = 1'b0;
    end else if (accept) begin
      if (state_q == IDLE) begin
        mode_d = ascii_mode_t'(mode);
      end
      if (!is_term) begin
        if (full) begin
          overflow_d = 1'b1;
        end else begin
          wr_ptr_d = wr_ptr_q + OneCnt;
        end
        // When full, wr_ptr_q already equals DEPTH, which is the saturated position.
        if (!is_valid && !invalid_q) begin
          invalid_d = 1'b1;
          err_pos_d = wr_ptr_q;
        end
      end
      if (payload_last) begin
        len_d   = wr_ptr_d;
        state_d = DONE;
      end else begin
        state_d = RECV;
      end
    end
  end

  // Out-of-range reads are masked with a registered flag so the RAM read stays reset-free.
  assign rd_zero_d = clear || ({1'b0, rd_addr} >= len_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= MODE_DEC;
      wr_ptr_q   <= '0;
      len_q      <= '0;
      err_pos_q  <= '0;
      invalid_q  <= 1'b0;
      overflow_q <= 1'b0;
      rd_zero_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      wr_ptr_q   <= wr_ptr_d;
      len_q      <= len_d;
      err_pos_q  <= err_pos_d;
      invalid_q  <= invalid_d;
      overflow_q <= overflow_d;
      rd_zero_q  <= rd_zero_d;
    end
  end

  // Simple dual-port RAM: one write port, one registered read port, no reset.
  always_ff @(posedge clk) begin
    if (store) begin
      ram[wr_ptr_q[ADDR_W-1:0]] <= mapped_ch;
    end
    ram_rd_q <= ram[rd_addr];
  end

  assign rd_data       = rd_zero_q ? 8'h00 : ram_rd_q;
  assign buffer_length = len_q;
  assign done          = (state_q == DONE);
  assign invalid       = invalid_q;
  assign err_pos       = err_pos_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_ascii_frame_validator.sv
module tb_ascii_frame_validator;
  import ascii_sep_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, clear;
  logic [1:0] mode;
  logic [7:0] payload_data;
  logic       payload_valid, payload_last;
  logic [3:0] rd_addr;

  logic       b_ready, b_done, b_inv, b_ovf;
  logic [7:0] b_rd_data;
  logic [4:0] b_len, b_err;
  logic       s_ready, s_done, s_inv, s_ovf;
  logic [7:0] s_rd_data;
  logic [2:0] s_len, s_err;

  always #5 clk = ~clk;

  ascii_frame_validator #(.DEPTH(16), .MAP_TAB(1'b1)) u_big (
    .clk (clk), .rst_n (rst_n), .clear (clear), .mode (mode),
    .payload_data (payload_data), .payload_valid (payload_valid),
    .payload_last (payload_last), .payload_ready (b_ready),
    .rd_addr (rd_addr), .rd_data (b_rd_data), .buffer_length (b_len),
    .done (b_done), .invalid (b_inv), .err_pos (b_err), .overflow (b_ovf)
  );

  ascii_frame_validator #(.DEPTH(4), .MAP_TAB(1'b1)) u_small (
    .clk (clk), .rst_n (rst_n), .clear (clear), .mode (mode),
    .payload_data (payload_data), .payload_valid (payload_valid),
    .payload_last (payload_last), .payload_ready (s_ready),
    .rd_addr (rd_addr[1:0]), .rd_data (s_rd_data), .buffer_length (s_len),
    .done (s_done), .invalid (s_inv), .err_pos (s_err), .overflow (s_ovf)
  );

  typedef struct packed {
    logic [63:0] frame;
    logic [3:0]  n_in;
    logic [1:0]  mode;
    logic [63:0] stored;
    logic [3:0]  n_st;
    logic        inv;
    logic [4:0]  err;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(input string f, input logic [1:0] m, input string s,
                              input logic inv, input logic [4:0] err);
    vec_t v;
    v = '0;
    for (int i = 0; i < f.len(); i++) v.frame[8*i +: 8] = f[i];
    for (int i = 0; i < s.len(); i++) v.stored[8*i +: 8] = s[i];
    v.n_in = 4'(f.len());
    v.n_st = 4'(s.len());
    v.mode = m;
    v.inv  = inv;
    v.err  = err;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    payload_valid = 1'b0;
    payload_last  = 1'b0;
    clear         = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Called just after a negedge; the beat is taken at the following posedge.
  task automatic beat(input logic [7:0] d, input logic last, input logic [1:0] m);
    payload_data  = d;
    payload_valid = 1'b1;
    payload_last  = last;
    mode          = m;
    chk("ready_during_frame", int'(b_ready), 1);
    @(negedge clk);
    payload_valid = 1'b0;
    payload_last  = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    do_clear();
    for (int i = 0; i < int'(v.n_in); i++) begin
      beat(v.frame[8*i +: 8], (i == int'(v.n_in) - 1), v.mode);
    end
    chk({tag, "_done"}, int'(b_done), 1);
    chk({tag, "_ready_low"}, int'(b_ready), 0);
    chk({tag, "_len"}, int'(b_len), int'(v.n_st));
    chk({tag, "_invalid"}, int'(b_inv), int'(v.inv));
    chk({tag, "_err_pos"}, int'(b_err), int'(v.err));
    chk({tag, "_overflow"}, int'(b_ovf), 0);
    for (int a = 0; a <= int'(v.n_st); a++) begin
      rd_addr = 4'(a);
      @(negedge clk);
      chk($sformatf("%s_rd%0d", tag, a), int'(b_rd_data),
          (a < int'(v.n_st)) ? int'(v.stored[8*a +: 8]) : 0);
    end
  endtask

  vec_t vecs [11];
  string s_ovf_str;

  initial begin
    vecs[0]  = mk("12 -3\r\n", MODE_DEC,   "12 -3",   1'b0, 5'd0);
    vecs[1]  = mk("1A 2",      MODE_DEC,   "1A 2",    1'b1, 5'd1);
    vecs[2]  = mk("1A 2",      MODE_HEX,   "1A 2",    1'b0, 5'd0);
    vecs[3]  = mk("1\t2",      MODE_DEC,   "1 2",     1'b0, 5'd0);
    vecs[4]  = mk("\r\n",      MODE_DEC,   "",        1'b0, 5'd0);
    vecs[5]  = mk("-1.5e+3",   MODE_FLOAT, "-1.5e+3", 1'b0, 5'd0);
    vecs[6]  = mk("9x8y\n",    MODE_DEC,   "9x8y",    1'b1, 5'd1);
    vecs[7]  = mk("a~ Z",      MODE_PRINT, "a~ Z",    1'b0, 5'd0);
    vecs[8]  = mk("g0",        MODE_HEX,   "g0",      1'b1, 5'd0);
    vecs[9]  = mk("1\r2",      MODE_DEC,   "12",      1'b0, 5'd0);
    vecs[10] = mk("12.5",      MODE_DEC,   "12.5",    1'b1, 5'd2);

    rst_n = 1'b0; clear = 1'b0; mode = 2'd0; payload_data = 8'h00;
    payload_valid = 1'b0; payload_last = 1'b0; rd_addr = 4'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", int'(b_ready), 1);
    chk("rst_done", int'(b_done), 0);
    chk("rst_len", int'(b_len), 0);
    chk("rst_invalid", int'(b_inv), 0);
    chk("rst_err_pos", int'(b_err), 0);
    chk("rst_overflow", int'(b_ovf), 0);
    chk("rst_rd_data", int'(b_rd_data), 0);

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Overflow on the 4-deep instance: frame drains, excess bytes dropped.
    do_clear();
    s_ovf_str = "123456";
    for (int i = 0; i < 6; i++) begin
      chk("small_ready_drain", int'(s_ready), 1);
      beat(s_ovf_str[i], (i == 5), MODE_DEC);
    end
    chk("ovf_done", int'(s_done), 1);
    chk("ovf_flag", int'(s_ovf), 1);
    chk("ovf_len", int'(s_len), 4);
    chk("ovf_invalid", int'(s_inv), 0);
    chk("ovf_big_len", int'(b_len), 6);
    for (int a = 0; a < 4; a++) begin
      rd_addr = 4'(a);
      @(negedge clk);
      chk($sformatf("ovf_rd%0d", a), int'(s_rd_data), 8'h31 + a);
    end

    // Dropped invalid byte is the first invalid one: err_pos saturates at DEPTH.
    do_clear();
    s_ovf_str = "1234x\n";
    for (int i = 0; i < 6; i++) beat(s_ovf_str[i], (i == 5), MODE_DEC);
    chk("sat_overflow", int'(s_ovf), 1);
    chk("sat_invalid", int'(s_inv), 1);
    chk("sat_err_pos", int'(s_err), 4);
    chk("sat_len", int'(s_len), 4);
    chk("sat_big_err_pos", int'(b_err), 4);
    chk("sat_big_overflow", int'(b_ovf), 0);

    // Mode is latched on the first beat only.
    do_clear();
    beat(8'h31, 1'b0, MODE_HEX);
    beat(8'h66, 1'b0, MODE_DEC);
    beat(8'h66, 1'b1, MODE_DEC);
    chk("latch_done", int'(b_done), 1);
    chk("latch_invalid", int'(b_inv), 0);
    chk("latch_len", int'(b_len), 3);

    // Clear coinciding with a beat mid-frame drops the byte and resets everything.
    do_clear();
    beat(8'h78, 1'b0, MODE_DEC);
    beat(8'h32, 1'b0, MODE_DEC);
    chk("pre_clear_invalid", int'(b_inv), 1);
    payload_data = 8'h33; payload_valid = 1'b1; clear = 1'b1;
    @(negedge clk);
    payload_valid = 1'b0; clear = 1'b0;
    chk("clr_ready", int'(b_ready), 1);
    chk("clr_done", int'(b_done), 0);
    chk("clr_len", int'(b_len), 0);
    chk("clr_invalid", int'(b_inv), 0);
    chk("clr_err_pos", int'(b_err), 0);
    chk("clr_overflow", int'(b_ovf), 0);
    beat(8'h37, 1'b1, MODE_DEC);
    chk("clr_new_done", int'(b_done), 1);
    chk("clr_new_len", int'(b_len), 1);
    rd_addr = 4'd0;
    @(negedge clk);
    chk("clr_new_rd0", int'(b_rd_data), 8'h37);
    rd_addr = 4'd1;
    @(negedge clk);
    chk("clr_new_rd1", int'(b_rd_data), 0);

    // Reset mid-frame.
    do_clear();
    beat(8'h31, 1'b0, MODE_DEC);
    beat(8'h78, 1'b0, MODE_DEC);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_ready", int'(b_ready), 1);
    chk("midrst_done", int'(b_done), 0);
    chk("midrst_invalid", int'(b_inv), 0);
    chk("midrst_len", int'(b_len), 0);
    chk("midrst_rd_data", int'(b_rd_data), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
